alu_op_scheduler: RTL and testbench
===================================

# alu_op_scheduler

Round-robin scheduler that shares one 8-bit `Alu` datapath between two requesters. Each requester submits an operation (`{Op,S1,S0}` opcode, A, B, Carry_in) over a valid/ready handshake. The block captures the operands, holds them stable on the ALU for a fixed settle window, registers the ALU outputs, and returns them on a single tagged response channel. It sits between the ALU and the two command sources, for example a sequencer and a debug/test port.

## Interface
Parameters:
- `WIDTH`, 8, operand and result width; must match `Alu`.
- `EXEC_CYCLES`, 2, cycles operands are held on the ALU before the outputs are sampled; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_op`  in  3  opcode `{Op,S1,S0}`.
- `req0_a`, `req0_b`  in  WIDTH  operands.
- `req0_cin`  in  1  carry-in; meaningful only for ADD/SUB.
- `req1_*`  same set as `req0_*`, for requester 1.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  1  requester that issued the operation.
- `rsp_result`  out  WIDTH  ALU `Result`.
- `rsp_remainder`  out  WIDTH  ALU `Remainder`.
- `rsp_overflow`  out  1  ALU `Overflow_flag`, or the divide-by-zero error flag.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - EXEC: operands applied to the ALU, cycle counter running.
  - RESP: `rsp_valid` high, waiting on `rsp_ready`.
- Arbitration happens only in IDLE.
  - If exactly one `reqN_valid` is high, that requester wins.
  - If both are high, the requester not granted last wins.
  - The last-grant pointer resets to 1, so requester 0 wins the first tie.
- `reqN_ready` is combinational: high only in IDLE, only for the winner, only while that requester's valid is high. Never both high.
- On a handshake (valid & ready), register the op, A, B, cin and id, update the last-grant pointer, and transition:
  - DIV with B == 0 goes directly to RESP.
  - Every other opcode goes to EXEC with the counter set to `EXEC_CYCLES-1`.
- EXEC:
  - Registered operands drive `Alu` continuously.
  - The counter decrements each cycle.
  - When it is 0, latch `Result`/`Remainder`/`Overflow_flag` into the response registers and go to RESP.
- Divide-by-zero (opcode 011, B == 0) never launches the ALU. The response is `rsp_result` = all ones, `rsp_remainder` = A, `rsp_overflow` = 1.
- RESP: response registers are held stable. When `rsp_valid & rsp_ready`, go to IDLE. No new grant is issued in that same cycle.
- Requesters must hold valid and payload stable until ready. The block does not check this.
- Opcode constants: ADD 000, SUB 001, MUL 010, DIV 011, LOGIC0 100, LOGIC1 101. Other codes are passed to the ALU unchanged.

## Timing
- Reset:
  - State IDLE, counter 0, last-grant pointer 1.
  - All response registers 0.
  - `rsp_valid`, `busy`, `req0_ready`, `req1_ready` all 0 in the cycle after reset.
- Reset asserted mid-EXEC or mid-RESP aborts the operation: no response is produced and the pointer returns to 1.
- Latency from the accept edge to `rsp_valid` high:
  - `EXEC_CYCLES` cycles for normal ops.
  - 1 cycle for divide-by-zero.
- Minimum issue interval with `rsp_ready` held high is `EXEC_CYCLES`+2 cycles.
- Ready falls the cycle after accept. Valid and payload on the losing port are ignored until the next IDLE.
- `busy` = (state != IDLE), registered.

## Structure
- Package `alu_sched_pkg`:
  - Opcode constants (ADD, SUB, MUL, DIV, LOGIC0, LOGIC1).
  - FSM state enum (IDLE, EXEC, RESP).
  - `EXEC_CNT_W` = 4.
- One sub-module: the existing `Alu`, instantiated once and driven only from the registered operand set.
- The arbiter is inline logic, not a separate module.

## Test plan
- Single op: req0 issues ADD, A=90, B=33, cin=0 → one `rsp_valid` pulse after `EXEC_CYCLES` with `rsp_id`=0, `rsp_result`=123, `rsp_overflow`=0.
- Carry/overflow: req1 issues ADD, A=254, B=5, cin=1 → `rsp_result`=4, `rsp_overflow`=1, `rsp_id`=1.
- Tie arbitration: both requesters hold valid with MUL 13×10 (req0) and DIV 245/75 (req1) → req0 served first (`rsp_result`=130); after the response handshake req1 is served (`rsp_result`=3, `rsp_remainder`=20). A second tie then grants req1 first.
- Divide-by-zero: DIV, A=23, B=0 → `rsp_valid` one cycle after accept, `rsp_result`=8'hFF, `rsp_remainder`=23, `rsp_overflow`=1.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → response stable, both readies low, `busy`=1. Then `rsp_ready`=1 → IDLE next cycle.
- Reset mid-EXEC: assert `rst` during EXEC → no `rsp_valid`, all outputs 0 the next cycle, and a subsequent tie grants req0.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU operation scheduler.
//   - opcode constants for the {Op,S1,S0} field
//   - scheduler FSM state type
//   - width of the execute-window down-counter
package alu_sched_pkg;

    localparam int EXEC_CNT_W = 4;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_MUL    = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b011;
    localparam logic [2:0] OP_LOGIC0 = 3'b100;
    localparam logic [2:0] OP_LOGIC1 = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_scheduler_alu.sv
// Alu: combinational WIDTH-bit arithmetic/logic unit.
// Ports:
//   Op, S1, S0     in   opcode bits {Op,S1,S0}
//   A, B           in   operands
//   Carry_in       in   carry (ADD) / borrow (SUB) input
//   Result         out  primary result (low product half for MUL, quotient for DIV)
//   Remainder      out  high product half for MUL, remainder for DIV, else 0
//   Overflow_flag  out  carry-out (ADD), borrow-out (SUB), nonzero high half (MUL),
//                       divide-by-zero (DIV)
module Alu
    import alu_sched_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Op,
    input  logic             S1,
    input  logic             S0,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Carry_in,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Remainder,
    output logic             Overflow_flag
);

    logic [2:0]         opc;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;

    always_comb begin
        opc  = {Op, S1, S0};
        prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        sum  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Carry_in};
        // Top bit of the widened difference is the borrow-out.
        diff = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, Carry_in};

        Result        = '0;
        Remainder     = '0;
        Overflow_flag = 1'b0;

        case (opc)
            OP_ADD: {Overflow_flag, Result} = sum;
            OP_SUB: {Overflow_flag, Result} = diff;
            OP_MUL: begin
                Result        = prod[WIDTH-1:0];
                Remainder     = prod[2*WIDTH-1:WIDTH];
                Overflow_flag = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                if (B == '0) begin
                    Result        = '1;
                    Remainder     = A;
                    Overflow_flag = 1'b1;
                end else begin
                    Result    = A / B;
                    Remainder = A % B;
                end
            end
            OP_LOGIC0: Result = A & B;
            OP_LOGIC1: Result = A | B;
            3'b110:    Result = A ^ B;
            default:   Result = ~A;
        endcase
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: round-robin sharing of one Alu between two requesters.
// An accepted operation is registered, held on the Alu for EXEC_CYCLES cycles,
// and the sampled outputs are returned on a single tagged response channel.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid / reqN_ready   per-requester handshake (N = 0, 1)
//   reqN_op/_a/_b/_cin        per-requester opcode and operands
//   rsp_valid / rsp_ready     response handshake
//   rsp_id                    requester that issued the returned operation
//   rsp_result/_remainder     Alu Result / Remainder
//   rsp_overflow              Alu Overflow_flag or divide-by-zero error
//   busy                      high whenever the FSM is not in IDLE
module alu_op_scheduler
    import alu_sched_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EXEC_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic             rsp_overflow,
    output logic             busy
);

    localparam logic [EXEC_CNT_W-1:0] CNT_INIT = EXEC_CNT_W'(EXEC_CYCLES - 1);

    state_t                state;
    state_t                next_state;
    logic [EXEC_CNT_W-1:0] cnt;
    logic                  last_grant;

    logic [2:0]            op_q;
    logic [WIDTH-1:0]      a_q;
    logic [WIDTH-1:0]      b_q;
    logic                  cin_q;
    logic                  id_q;
    logic [WIDTH-1:0]      res_q;
    logic [WIDTH-1:0]      rem_q;
    logic                  ovf_q;

    logic                  grant1;
    logic                  accept;
    logic [2:0]            sel_op;
    logic [WIDTH-1:0]      sel_a;
    logic [WIDTH-1:0]      sel_b;
    logic                  sel_cin;
    logic                  sel_div0;

    logic [WIDTH-1:0]      alu_result;
    logic [WIDTH-1:0]      alu_remainder;
    logic                  alu_overflow;

    // Alu sees only the registered operand set, so its inputs are stable
    // for the whole execute window regardless of requester behaviour.
    Alu #(.WIDTH(WIDTH)) u_alu (
        .Op            (op_q[2]),
        .S1            (op_q[1]),
        .S0            (op_q[0]),
        .A             (a_q),
        .B             (b_q),
        .Carry_in      (cin_q),
        .Result        (alu_result),
        .Remainder     (alu_remainder),
        .Overflow_flag (alu_overflow)
    );

    always_comb begin
        // Requester 1 wins when alone, or on a tie when requester 0 was last.
        grant1     = req1_valid && (!req0_valid || !last_grant);
        req0_ready = (state == IDLE) && req0_valid && !grant1;
        req1_ready = (state == IDLE) && grant1;
        accept     = req0_ready || req1_ready;

        sel_op   = grant1 ? req1_op  : req0_op;
        sel_a    = grant1 ? req1_a   : req0_a;
        sel_b    = grant1 ? req1_b   : req0_b;
        sel_cin  = grant1 ? req1_cin : req0_cin;
        sel_div0 = (sel_op == OP_DIV) && (sel_b == '0);

        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = sel_div0 ? RESP : EXEC;
            EXEC:    if (cnt == '0) next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            last_grant <= 1'b1;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            id_q       <= 1'b0;
            res_q      <= '0;
            rem_q      <= '0;
            ovf_q      <= 1'b0;
        end else if (accept) begin
            op_q       <= sel_op;
            a_q        <= sel_a;
            b_q        <= sel_b;
            cin_q      <= sel_cin;
            id_q       <= grant1;
            last_grant <= grant1;
            if (sel_div0) begin
                // Error response is formed directly; the Alu is never launched.
                res_q <= '1;
                rem_q <= sel_a;
                ovf_q <= 1'b1;
            end else begin
                cnt <= CNT_INIT;
            end
        end else if (state == EXEC) begin
            if (cnt == '0) begin
                res_q <= alu_result;
                rem_q <= alu_remainder;
                ovf_q <= alu_overflow;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign rsp_valid     = (state == RESP);
    assign busy          = (state != IDLE);
    assign rsp_id        = id_q;
    assign rsp_result    = res_q;
    assign rsp_remainder = rem_q;
    assign rsp_overflow  = ovf_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Self-checking bench for alu_op_scheduler: table-driven single operations,
// hand sequences for arbitration ties, backpressure and reset mid-EXEC.
// Expected responses go into a scoreboard queue when stimulus is driven and
// are compared when the response handshake occurs.
module tb_alu_op_scheduler;
    import alu_sched_pkg::*;

    localparam int WIDTH       = 8;
    localparam int EXEC_CYCLES = 2;

    typedef struct {
        logic       port;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] res;
        logic [7:0] rem;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic       id;
        logic [7:0] res;
        logic [7:0] rem;
        logic       ovf;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_cin;
    logic [2:0] req0_op;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_cin;
    logic [2:0] req1_op;
    logic [7:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_overflow, busy;
    logic [7:0] rsp_result, rsp_remainder;

    int   total = 0;
    int   bad   = 0;
    rsp_t exp_q[$];
    vec_t vecs[10];

    alu_op_scheduler #(.WIDTH(WIDTH), .EXEC_CYCLES(EXEC_CYCLES)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_op       (req0_op),
        .req0_a        (req0_a),
        .req0_b        (req0_b),
        .req0_cin      (req0_cin),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_op       (req1_op),
        .req1_a        (req1_a),
        .req1_b        (req1_b),
        .req1_cin      (req1_cin),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_result    (rsp_result),
        .rsp_remainder (rsp_remainder),
        .rsp_overflow  (rsp_overflow),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic port, input logic valid, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b, input logic cin);
        if (port) begin
            req1_valid = valid; req1_op = op; req1_a = a; req1_b = b; req1_cin = cin;
        end else begin
            req0_valid = valid; req0_op = op; req0_a = a; req0_b = b; req0_cin = cin;
        end
    endtask

    // Returns at the negedge where the port's ready is seen high (accept on next posedge).
    task automatic wait_ready(input logic port, output bit got);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (port ? req1_ready : req0_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: port %0d ready stayed 0, expected 1", port);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!busy && exp_q.size() == 0) break;
        end
        check("drain_busy", busy, 0);
        check("drain_queue", exp_q.size(), 0);
    endtask

    task automatic wait_rsp_valid(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        bit got;
        exp_q.push_back('{v.port, v.res, v.rem, v.ovf});
        drive(v.port, 1'b1, v.op, v.a, v.b, v.cin);
        wait_ready(v.port, got);
        @(posedge clk); #1;
        drive(v.port, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
        check("ready_fall", v.port ? req1_ready : req0_ready, 0);
        wait_rsp_valid(lat);
        check("latency", lat, (v.op == OP_DIV && v.b == 8'd0) ? 0 : EXEC_CYCLES);
        wait_idle();
    endtask

    initial begin
        int  lat;
        bit  got;
        rst = 1'b1;
        rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
        drive(1'b1, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);

        vecs[0] = '{1'b0, OP_ADD,    8'd90,  8'd33, 1'b0, 8'd123, 8'd0,  1'b0};
        vecs[1] = '{1'b1, OP_ADD,    8'd254, 8'd5,  1'b1, 8'd4,   8'd0,  1'b1};
        vecs[2] = '{1'b0, OP_SUB,    8'd10,  8'd3,  1'b1, 8'd6,   8'd0,  1'b0};
        vecs[3] = '{1'b1, OP_SUB,    8'd3,   8'd5,  1'b0, 8'd254, 8'd0,  1'b1};
        vecs[4] = '{1'b0, OP_MUL,    8'd13,  8'd10, 1'b0, 8'd130, 8'd0,  1'b0};
        vecs[5] = '{1'b1, OP_MUL,    8'd200, 8'd3,  1'b0, 8'd88,  8'd2,  1'b1};
        vecs[6] = '{1'b0, OP_DIV,    8'd245, 8'd75, 1'b0, 8'd3,   8'd20, 1'b0};
        vecs[7] = '{1'b1, OP_DIV,    8'd23,  8'd0,  1'b0, 8'd255, 8'd23, 1'b1};
        vecs[8] = '{1'b0, OP_LOGIC0, 8'hF0,  8'h3C, 1'b0, 8'h30,  8'd0,  1'b0};
        vecs[9] = '{1'b1, OP_LOGIC1, 8'hF0,  8'h3C, 1'b0, 8'hFC,  8'd0,  1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_r0", req0_ready, 0);
        check("rst_r1", req1_ready, 0);
        check("rst_result", rsp_result, 0);
        check("rst_remainder", rsp_remainder, 0);
        check("rst_overflow", rsp_overflow, 0);
        check("rst_id", rsp_id, 0);
        rst = 1'b0;

        fork
            forever begin
                rsp_t e;
                @(negedge clk);
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rsp: got id=%0d result=%0h, expected no response",
                                 rsp_id, rsp_result);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_id", rsp_id, e.id);
                        check("rsp_result", rsp_result, e.res);
                        check("rsp_remainder", rsp_remainder, e.rem);
                        check("rsp_overflow", rsp_overflow, e.ovf);
                    end
                end
            end
        join_none

        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Tie: pointer last granted req1, so req0 wins first; req0 re-presents
        // immediately, creating a second tie that req1 must win.
        exp_q.push_back('{1'b0, 8'd130, 8'd0,  1'b0});
        exp_q.push_back('{1'b1, 8'd3,   8'd20, 1'b0});
        exp_q.push_back('{1'b0, 8'd3,   8'd0,  1'b0});
        drive(1'b0, 1'b1, OP_MUL, 8'd13,  8'd10, 1'b0);
        drive(1'b1, 1'b1, OP_DIV, 8'd245, 8'd75, 1'b0);
        @(negedge clk);
        check("tie1_r0", req0_ready, 1);
        check("tie1_r1", req1_ready, 0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, OP_ADD, 8'd1, 8'd2, 1'b0);
        check("tie1_exec_r0", req0_ready, 0);
        check("tie1_exec_r1", req1_ready, 0);
        wait_ready(1'b1, got);
        check("tie2_r0", req0_ready, 0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
        wait_ready(1'b0, got);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
        wait_idle();

        // Backpressure in RESP
        rsp_ready = 1'b0;
        exp_q.push_back('{1'b0, 8'd15, 8'd0, 1'b0});
        drive(1'b0, 1'b1, OP_ADD, 8'd7, 8'd8, 1'b0);
        wait_ready(1'b0, got);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
        wait_rsp_valid(lat);
        check("bp_latency", lat, EXEC_CYCLES);
        drive(1'b0, 1'b1, OP_SUB, 8'd9, 8'd9, 1'b0);
        drive(1'b1, 1'b1, OP_ADD, 8'd1, 8'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_result", rsp_result, 15);
            check("bp_busy", busy, 1);
            check("bp_r0", req0_ready, 0);
            check("bp_r1", req1_ready, 0);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
        drive(1'b1, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_busy", busy, 0);
        check("bp_release_valid", rsp_valid, 0);
        check("bp_queue", exp_q.size(), 0);

        // Reset mid-EXEC: req0 granted last, so without reset a tie would go to req1.
        drive(1'b0, 1'b1, OP_ADD, 8'd1, 8'd1, 1'b0);
        wait_ready(1'b0, got);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
        check("mid_exec_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_valid", rsp_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_result", rsp_result, 0);
        check("mrst_remainder", rsp_remainder, 0);
        check("mrst_overflow", rsp_overflow, 0);
        check("mrst_id", rsp_id, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("mrst_no_rsp", rsp_valid, 0);
        end
        exp_q.push_back('{1'b0, 8'd5, 8'd0, 1'b0});
        exp_q.push_back('{1'b1, 8'd6, 8'd0, 1'b0});
        drive(1'b0, 1'b1, OP_ADD, 8'd2, 8'd3, 1'b0);
        drive(1'b1, 1'b1, OP_ADD, 8'd2, 8'd4, 1'b0);
        @(negedge clk);
        check("mrst_tie_r0", req0_ready, 1);
        check("mrst_tie_r1", req1_ready, 0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
        wait_ready(1'b1, got);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
